// File: rtl/instr_fetch_unit.sv
// Program counter and instruction-fetch stage.
// Holds the current PC and fetches one 32-bit word per PC over a req/ack
// handshake. It hands the word to decode over a valid/ready handshake.
// Memory timeouts are retried a bounded number of times before the unit
// parks in ERROR. Misaligned PC loads are rejected and flagged.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned TIMEOUT     = 8,
  parameter int unsigned MAX_RETRIES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] NewPC,
  input  logic        PCLoad,
  output logic [15:0] OldPC,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic        Misaligned,
  output logic        FetchError,
  output logic [15:0] FetchCount
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_RETRY,
    S_HOLD,
    S_WAIT_PC,
    S_ERROR
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] RT_MAX  = 8'(MAX_RETRIES);

  state_t      state, state_nx;
  logic        run;
  logic [7:0]  tcnt;
  logic [7:0]  rcnt;
  logic [15:0] pc;
  logic [31:0] instr;
  logic [15:0] fcnt;
  logic        mis;

  logic        aligned;
  logic        pc_load;
  logic        set_mis;
  logic        capture;
  logic        tcnt_inc;
  logic        tcnt_clr;
  logic        rcnt_inc;

  // run holds imem_req low during the first cycle after reset. The request
  // then rises only once reset has been sampled low, and any ack seen while
  // reset is still settling is ignored.
  assign imem_req    = (state == S_FETCH) && run;
  assign imem_addr   = pc;
  assign OldPC       = pc;
  assign Instruction = instr;
  assign InstrValid  = (state == S_HOLD);
  assign FetchError  = (state == S_ERROR);
  assign Misaligned  = mis;
  assign FetchCount  = fcnt;
  assign aligned     = (NewPC[1:0] == 2'b00);

  // Next-state and datapath control decode
  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    set_mis  = 1'b0;
    capture  = 1'b0;
    tcnt_inc = 1'b0;
    tcnt_clr = 1'b0;
    rcnt_inc = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (run) begin
          if (imem_ack) begin
            capture  = 1'b1;
            state_nx = S_HOLD;
          end else if (tcnt == TO_LAST) begin
            tcnt_clr = 1'b1;
            state_nx = S_RETRY;
          end else begin
            tcnt_inc = 1'b1;
          end
        end
      end
      S_RETRY: begin
        rcnt_inc = 1'b1;
        tcnt_clr = 1'b1;
        if (rcnt + 8'd1 == RT_MAX) state_nx = S_ERROR;
        else                       state_nx = S_FETCH;
      end
      S_HOLD: begin
        if (InstrReady) begin
          // A misaligned target on the combined accept+load is rejected the
          // same way as in WAIT_PC, so the unit then waits for a good PC.
          if (PCLoad && aligned) begin
            pc_load  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            set_mis  = PCLoad;
            state_nx = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (PCLoad) begin
          if (aligned) begin
            pc_load  = 1'b1;
            state_nx = S_FETCH;
          end else begin
            set_mis  = 1'b1;
          end
        end
      end
      S_ERROR: state_nx = S_ERROR;
      default: state_nx = S_FETCH;
    endcase
  end

  // State, PC, instruction latch, counters and sticky flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      run   <= 1'b0;
      tcnt  <= '0;
      rcnt  <= '0;
      pc    <= RESET_PC;
      instr <= '0;
      fcnt  <= '0;
      mis   <= 1'b0;
    end else begin
      state <= state_nx;
      run   <= 1'b1;
      if (capture) begin
        instr <= imem_rdata;
        fcnt  <= fcnt + 16'd1;
        rcnt  <= '0;
        tcnt  <= '0;
      end else begin
        if (tcnt_clr)      tcnt <= '0;
        else if (tcnt_inc) tcnt <= tcnt + 8'd1;
        if (rcnt_inc)      rcnt <= rcnt + 8'd1;
      end
      if (pc_load) pc  <= NewPC;
      if (set_mis) mis <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with hand-computed expectations.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic [15:0] NewPC;
  logic        PCLoad;
  logic [15:0] OldPC;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic        InstrReady;
  logic        Misaligned;
  logic        FetchError;
  logic [15:0] FetchCount;

  int unsigned total;
  int unsigned bad;

  instr_fetch_unit #(
    .RESET_PC   (16'h0000),
    .TIMEOUT    (8),
    .MAX_RETRIES(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .NewPC      (NewPC),
    .PCLoad     (PCLoad),
    .OldPC      (OldPC),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .Instruction(Instruction),
    .InstrValid (InstrValid),
    .InstrReady (InstrReady),
    .Misaligned (Misaligned),
    .FetchError (FetchError),
    .FetchCount (FetchCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    NewPC      = '0;
    PCLoad     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '0;
    InstrReady = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_pc", {16'h0, OldPC}, 32'h0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, InstrValid}, 32'h0);
    chk("rst_instr", Instruction, 32'h0);
    chk("rst_cnt", {16'h0, FetchCount}, 32'h0);
    chk("rst_err", {31'h0, FetchError}, 32'h0);
    chk("rst_mis", {31'h0, Misaligned}, 32'h0);

    // Basic fetch: ack after two request cycles
    reset = 1'b0;
    tick();
    chk("bf_req", {31'h0, imem_req}, 32'h1);
    chk("bf_addr", {16'h0, imem_addr}, 32'h0);
    tick();
    chk("bf_req2", {31'h0, imem_req}, 32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h2008_0005;
    tick();
    imem_ack   = 1'b0;
    chk("bf_valid", {31'h0, InstrValid}, 32'h1);
    chk("bf_instr", Instruction, 32'h2008_0005);
    chk("bf_cnt", {16'h0, FetchCount}, 32'h1);
    InstrReady = 1'b1;
    tick();
    chk("bf_valid_off", {31'h0, InstrValid}, 32'h0);
    chk("bf_req_off", {31'h0, imem_req}, 32'h0);

    // Load sequence with zero-latency acks
    NewPC  = 16'h0004;
    PCLoad = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("ld_pc4", {16'h0, OldPC}, 32'h4);
    chk("ld_addr4", {16'h0, imem_addr}, 32'h4);
    chk("ld_req4", {31'h0, imem_req}, 32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_2222;
    tick();
    imem_ack   = 1'b0;
    chk("ld_instr4", Instruction, 32'h1111_2222);
    tick();
    NewPC  = 16'h0040;
    PCLoad = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("ld_pc40", {16'h0, OldPC}, 32'h40);
    imem_ack   = 1'b1;
    imem_rdata = 32'h3333_4444;
    tick();
    imem_ack   = 1'b0;
    chk("ld_cnt3", {16'h0, FetchCount}, 32'h3);
    chk("ld_valid", {31'h0, InstrValid}, 32'h1);

    // Backpressure: HOLD with InstrReady low ignores PCLoad
    InstrReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      NewPC  = 16'h0020;
      PCLoad = 1'b1;
      tick();
      chk("bp_instr", Instruction, 32'h3333_4444);
      chk("bp_valid", {31'h0, InstrValid}, 32'h1);
      chk("bp_pc", {16'h0, OldPC}, 32'h40);
    end
    InstrReady = 1'b1;
    NewPC      = 16'h0010;
    PCLoad     = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("sim_valid", {31'h0, InstrValid}, 32'h0);
    chk("sim_req", {31'h0, imem_req}, 32'h1);
    chk("sim_pc", {16'h0, OldPC}, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'h5555_6666;
    tick();
    imem_ack = 1'b0;
    chk("sim_cnt", {16'h0, FetchCount}, 32'h4);
    tick();

    // Misaligned target rejected, then an aligned one accepted
    NewPC  = 16'h0006;
    PCLoad = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("mis_flag", {31'h0, Misaligned}, 32'h1);
    chk("mis_pc", {16'h0, OldPC}, 32'h10);
    chk("mis_req", {31'h0, imem_req}, 32'h0);
    tick();
    chk("mis_req2", {31'h0, imem_req}, 32'h0);
    NewPC  = 16'h0008;
    PCLoad = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("mis_pc8", {16'h0, OldPC}, 32'h8);
    chk("mis_req8", {31'h0, imem_req}, 32'h1);
    chk("mis_sticky", {31'h0, Misaligned}, 32'h1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_8888;
    tick();
    imem_ack = 1'b0;
    chk("mis_instr8", Instruction, 32'h7777_8888);

    // Timeout and error: 8 request cycles, 1 retry cycle, three times
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 35; k++) begin
      PCLoad = (k > 28);
      NewPC  = 16'h0100;
      tick();
      chk("to_req", {31'h0, imem_req}, {31'h0, (k <= 27) && (k % 9 != 0)});
      chk("to_err", {31'h0, FetchError}, {31'h0, k >= 28});
    end
    PCLoad = 1'b0;
    chk("to_pc", {16'h0, OldPC}, 32'h0);
    reset = 1'b1;
    tick();
    chk("to_rst_err", {31'h0, FetchError}, 32'h0);
    chk("to_rst_mis", {31'h0, Misaligned}, 32'h0);
    reset = 1'b0;
    tick();
    chk("to_refetch_req", {31'h0, imem_req}, 32'h1);
    chk("to_refetch_addr", {16'h0, imem_addr}, 32'h0);

    // Reset in FETCH with a same-cycle ack
    imem_ack   = 1'b1;
    imem_rdata = 32'hAAAA_0001;
    tick();
    imem_ack = 1'b0;
    NewPC    = 16'h0080;
    PCLoad   = 1'b1;
    tick();
    PCLoad = 1'b0;
    chk("mid_pc80", {16'h0, OldPC}, 32'h80);
    chk("mid_req", {31'h0, imem_req}, 32'h1);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("mid_valid", {31'h0, InstrValid}, 32'h0);
    chk("mid_pc", {16'h0, OldPC}, 32'h0);
    chk("mid_instr", Instruction, 32'h0);
    chk("mid_cnt", {16'h0, FetchCount}, 32'h0);
    tick();
    reset = 1'b0;
    chk("mid_valid2", {31'h0, InstrValid}, 32'h0);
    imem_ack = 1'b0;
    tick();
    chk("mid_req2", {31'h0, imem_req}, 32'h1);

    // FetchCount wrap: back-to-back fetches, two cycles each
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0013;
    InstrReady = 1'b1;
    NewPC      = 16'h0000;
    PCLoad     = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      tick();
      tick();
    end
    chk("wrap_ffff", {16'h0, FetchCount}, 32'hFFFF);
    chk("wrap_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk("wrap_zero", {16'h0, FetchCount}, 32'h0);
    chk("wrap_valid", {31'h0, InstrValid}, 32'h1);
    imem_ack = 1'b0;
    PCLoad   = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
